// File: rtl/qr_chk_pkg.sv
// Shared types for the QR result checker: FSM states and error classes.
package qr_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_DUT,
    S_START,
    S_RUN,
    S_DONE
  } chk_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_LEN      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/qr_gold_mem.sv
// Golden string store: per-pattern byte array plus length, one write port,
// combinational read. Not reset, so contents survive checker resets.
module qr_gold_mem #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 32,
  parameter int NUM_PAT = 40,
  parameter int PAT_W   = $clog2(NUM_PAT),
  parameter int IDX_W   = $clog2(MAX_LEN),
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              len_we,
  input  logic [PAT_W-1:0]  wr_pat,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  len_wdata,
  input  logic [PAT_W-1:0]  rd_pat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  rd_len
);

  logic [DATA_W-1:0] mem     [NUM_PAT][MAX_LEN];
  logic [LEN_W-1:0]  len_mem [NUM_PAT];

  logic wr_pat_ok, rd_pat_ok, wr_idx_ok, rd_idx_ok;

  // Pattern/index ranges need not be powers of two; out-of-range accesses are ignored.
  assign wr_pat_ok = 32'(wr_pat) < NUM_PAT;
  assign rd_pat_ok = 32'(rd_pat) < NUM_PAT;
  assign wr_idx_ok = 32'(wr_idx) < MAX_LEN;
  assign rd_idx_ok = 32'(rd_idx) < MAX_LEN;

  always_ff @(posedge clk) begin
    if (we && wr_pat_ok && wr_idx_ok) mem[wr_pat][wr_idx] <= wdata;
    if (len_we && wr_pat_ok)          len_mem[wr_pat]     <= len_wdata;
  end

  assign rd_data = (rd_pat_ok && rd_idx_ok) ? mem[rd_pat][rd_idx] : '0;
  assign rd_len  = rd_pat_ok ? len_mem[rd_pat] : '0;

endmodule

// File: rtl/qr_result_checker.sv
// Result checker for qr_decode: sequences decoder reset/start, compares the
// decoded byte stream against a stored golden string and reports the outcome.
module qr_result_checker
  import qr_chk_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MAX_LEN     = 32,
  parameter int NUM_PAT     = 40,
  parameter int TIMEOUT     = 1_000_000,
  parameter int CNT_W       = 32,
  parameter int STOP_ON_ERR = 1,
  parameter int PAT_W       = $clog2(NUM_PAT),
  parameter int IDX_W       = $clog2(MAX_LEN),
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              gold_we,
  input  logic [PAT_W-1:0]  gold_pat,
  input  logic [IDX_W-1:0]  gold_idx,
  input  logic [DATA_W-1:0] gold_wdata,
  input  logic              len_we,
  input  logic [LEN_W-1:0]  len_wdata,
  input  logic              chk_start,
  input  logic [PAT_W-1:0]  chk_pat,
  output logic              dut_srst,
  output logic              dut_start,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              dut_finish,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [1:0]        err_code,
  output logic [LEN_W-1:0]  err_idx,
  output logic [CNT_W-1:0]  pat_cycles,
  output logic [CNT_W-1:0]  total_cycles
);

  chk_state_e        state, state_nxt;
  logic [PAT_W-1:0]  cur_pat, cur_pat_nxt;
  logic [LEN_W-1:0]  hw_len, hw_len_nxt;
  logic [LEN_W-1:0]  err_idx_nxt;
  logic [1:0]        err_code_nxt, byte_err;
  logic [CNT_W-1:0]  cyc_nxt;
  logic              pass_nxt;
  logic              started;
  logic              start_acc;
  logic [DATA_W-1:0] gold_byte;
  logic [LEN_W-1:0]  gold_len;
  logic              wr_block;

  // Writes into the pattern being checked would corrupt the reference mid-run.
  assign wr_block = chk_busy && (gold_pat == cur_pat);

  qr_gold_mem #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .NUM_PAT(NUM_PAT),
    .PAT_W  (PAT_W),
    .IDX_W  (IDX_W),
    .LEN_W  (LEN_W)
  ) u_gold (
    .clk      (clk),
    .we       (gold_we && !wr_block),
    .len_we   (len_we && !wr_block),
    .wr_pat   (gold_pat),
    .wr_idx   (gold_idx),
    .wdata    (gold_wdata),
    .len_wdata(len_wdata),
    .rd_pat   (cur_pat),
    .rd_idx   (hw_len[IDX_W-1:0]),
    .rd_data  (gold_byte),
    .rd_len   (gold_len)
  );

  assign dut_srst  = (state == S_RST_DUT);
  assign dut_start = (state == S_START);
  assign chk_busy  = (state != S_IDLE);
  assign chk_done  = (state == S_DONE);
  assign start_acc = (state == S_IDLE) && chk_start;

  always_comb begin
    state_nxt    = state;
    cur_pat_nxt  = cur_pat;
    hw_len_nxt   = hw_len;
    err_code_nxt = err_code;
    err_idx_nxt  = err_idx;
    cyc_nxt      = pat_cycles;
    pass_nxt     = chk_pass;
    byte_err     = ERR_NONE;
    case (state)
      S_IDLE: if (chk_start) begin
        cur_pat_nxt  = chk_pat;
        hw_len_nxt   = '0;
        err_code_nxt = ERR_NONE;
        err_idx_nxt  = '0;
        cyc_nxt      = '0;
        pass_nxt     = 1'b0;
        state_nxt    = S_RST_DUT;
      end
      S_RST_DUT: state_nxt = S_START;
      S_START:   state_nxt = S_RUN;
      S_RUN: begin
        if (pat_cycles != '1) cyc_nxt = pat_cycles + 1'b1;
        if (dut_valid) begin
          if (hw_len >= gold_len)          byte_err = ERR_LEN;
          else if (dut_data != gold_byte)  byte_err = ERR_MISMATCH;
          if (byte_err != ERR_NONE && err_code == ERR_NONE) begin
            err_code_nxt = byte_err;
            err_idx_nxt  = hw_len;
          end
          if (hw_len != LEN_W'(MAX_LEN)) hw_len_nxt = hw_len + 1'b1;
        end
        // The byte of this cycle is already folded in before finish is judged.
        if (dut_finish) begin
          if (err_code_nxt == ERR_NONE && hw_len_nxt != gold_len) begin
            err_code_nxt = ERR_LEN;
            err_idx_nxt  = hw_len_nxt;
          end
          state_nxt = S_DONE;
        end else if (cyc_nxt == CNT_W'(TIMEOUT)) begin
          if (err_code_nxt == ERR_NONE) begin
            err_code_nxt = ERR_TIMEOUT;
            err_idx_nxt  = hw_len_nxt;
          end
          state_nxt = S_DONE;
        end else if (STOP_ON_ERR != 0 && err_code_nxt != ERR_NONE) begin
          state_nxt = S_DONE;
        end
        if (state_nxt == S_DONE) pass_nxt = (err_code_nxt == ERR_NONE);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= S_IDLE;
      cur_pat      <= '0;
      hw_len       <= '0;
      err_code     <= ERR_NONE;
      err_idx      <= '0;
      pat_cycles   <= '0;
      chk_pass     <= 1'b0;
      started      <= 1'b0;
      total_cycles <= '0;
    end else begin
      state      <= state_nxt;
      cur_pat    <= cur_pat_nxt;
      hw_len     <= hw_len_nxt;
      err_code   <= err_code_nxt;
      err_idx    <= err_idx_nxt;
      pat_cycles <= cyc_nxt;
      chk_pass   <= pass_nxt;
      started    <= started || start_acc;
      if ((started || start_acc) && total_cycles != '1)
        total_cycles <= total_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_qr_result_checker.sv
// Randomized bench for qr_result_checker against an event-list reference model.
module tb_qr_result_checker;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 32;
  localparam int NUM_PAT = 40;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 32;
  localparam int STOP    = 1;
  localparam int PAT_W   = $clog2(NUM_PAT);
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              srst = 1'b1;
  logic              gold_we = 1'b0, len_we = 1'b0;
  logic [PAT_W-1:0]  gold_pat = '0;
  logic [IDX_W-1:0]  gold_idx = '0;
  logic [DATA_W-1:0] gold_wdata = '0;
  logic [LEN_W-1:0]  len_wdata = '0;
  logic              chk_start = 1'b0;
  logic [PAT_W-1:0]  chk_pat = '0;
  logic              dut_srst, dut_start;
  logic              dut_valid = 1'b0, dut_finish = 1'b0;
  logic [DATA_W-1:0] dut_data = '0;
  logic              chk_busy, chk_done, chk_pass;
  logic [1:0]        err_code;
  logic [LEN_W-1:0]  err_idx;
  logic [CNT_W-1:0]  pat_cycles, total_cycles;

  qr_result_checker #(
    .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .STOP_ON_ERR(STOP)
  ) dut (
    .clk(clk), .srst(srst),
    .gold_we(gold_we), .gold_pat(gold_pat), .gold_idx(gold_idx), .gold_wdata(gold_wdata),
    .len_we(len_we), .len_wdata(len_wdata),
    .chk_start(chk_start), .chk_pat(chk_pat),
    .dut_srst(dut_srst), .dut_start(dut_start),
    .dut_valid(dut_valid), .dut_data(dut_data), .dut_finish(dut_finish),
    .chk_busy(chk_busy), .chk_done(chk_done), .chk_pass(chk_pass),
    .err_code(err_code), .err_idx(err_idx),
    .pat_cycles(pat_cycles), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int tb_cyc = 0, first_cyc = 0;
  bit started_m = 0;
  logic [7:0] gm [NUM_PAT][MAX_LEN];
  int gl [NUM_PAT];
  bit         ev_v [$];
  logic [7:0] ev_d [$];
  bit         ev_f [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  task automatic wr_byte(input int p, input int i, input logic [7:0] d);
    gold_we = 1'b1; gold_pat = PAT_W'(p); gold_idx = IDX_W'(i); gold_wdata = d;
    tick();
    gold_we = 1'b0;
    gm[p][i] = d;
  endtask

  task automatic wr_len(input int p, input int n);
    len_we = 1'b1; gold_pat = PAT_W'(p); len_wdata = LEN_W'(n);
    tick();
    len_we = 1'b0;
    gl[p] = n;
  endtask

  task automatic load_str(input int p, input string s);
    for (int i = 0; i < s.len(); i++) wr_byte(p, i, s[i]);
    wr_len(p, s.len());
  endtask

  task automatic load_rand(input int p);
    int n;
    n = $urandom_range(0, MAX_LEN);
    for (int i = 0; i < n; i++) wr_byte(p, i, 8'($urandom_range(32, 126)));
    wr_len(p, n);
  endtask

  // nbytes emitted; byte bad_at replaced by bad_val; finish on last byte or after; or never.
  task automatic build(input int p, input int nbytes, input int bad_at, input logic [7:0] bad_val,
                       input bit fin_last, input bit no_fin);
    logic [7:0] d;
    ev_v.delete(); ev_d.delete(); ev_f.delete();
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ev_v.push_back(1'b0); ev_d.push_back(8'($urandom)); ev_f.push_back(1'b0);
      end
      d = (i < gl[p]) ? gm[p][i] : 8'($urandom);
      if (i == bad_at) d = bad_val;
      ev_v.push_back(1'b1); ev_d.push_back(d);
      ev_f.push_back(!no_fin && fin_last && i == nbytes - 1);
    end
    if (no_fin) begin
      while (ev_v.size() < TIMEOUT + 5) begin
        ev_v.push_back(1'b0); ev_d.push_back(8'h00); ev_f.push_back(1'b0);
      end
    end else if (!fin_last || nbytes == 0) begin
      ev_v.push_back(1'b0); ev_d.push_back(8'h00); ev_f.push_back(1'b1);
    end
  endtask

  // Walks the event list applying the checking rules to predict the outcome.
  task automatic model(input int p, output int end_ev, output int code, output int idx, output int cyc);
    int cnt;
    cnt = 0; code = 0; idx = 0; cyc = 0; end_ev = -1;
    for (int j = 0; j < ev_v.size(); j++) begin
      cyc++;
      if (ev_v[j]) begin
        if (cnt >= gl[p]) begin
          if (code == 0) begin code = 2; idx = cnt; end
        end else if (ev_d[j] != gm[p][cnt]) begin
          if (code == 0) begin code = 1; idx = cnt; end
        end
        if (cnt < MAX_LEN) cnt++;
      end
      if (ev_f[j]) begin
        if (code == 0 && cnt != gl[p]) begin code = 2; idx = cnt; end
        end_ev = j; break;
      end
      if (cyc == TIMEOUT) begin
        if (code == 0) code = 3;
        end_ev = j; break;
      end
      if (STOP != 0 && code != 0) begin end_ev = j; break; end
    end
  endtask

  task automatic start_seq(input int p);
    chk_pat = PAT_W'(p); chk_start = 1'b1;
    if (!started_m) begin started_m = 1; first_cyc = tb_cyc; end
    tick();
    chk_start = 1'b0;
    chk("srst_pulse", 64'(dut_srst), 1);
    chk("busy_n1", 64'(chk_busy), 1);
    chk("pass_clr", 64'(chk_pass), 0);
    tick();
    chk("start_pulse", 64'(dut_start), 1);
    chk("srst_one", 64'(dut_srst), 0);
    tick();
  endtask

  task automatic run_check(input int p, input bit poke);
    int end_ev, code, idx, cyc, j;
    bit done;
    model(p, end_ev, code, idx, cyc);
    start_seq(p);
    j = 0; done = 0;
    while (!done && j < ev_v.size() + 4) begin
      dut_valid  = (j < ev_v.size()) ? ev_v[j] : 1'b0;
      dut_data   = (j < ev_v.size()) ? ev_d[j] : 8'h00;
      dut_finish = (j < ev_v.size()) ? ev_f[j] : 1'b0;
      // Attempt to overwrite the last golden byte of the pattern under check.
      if (poke && j == 0 && gl[p] > 1) begin
        gold_we = 1'b1; gold_pat = PAT_W'(p); gold_idx = IDX_W'(gl[p] - 1);
        gold_wdata = ~gm[p][gl[p] - 1];
      end
      tick();
      gold_we = 1'b0;
      j++;
      if (chk_done) done = 1;
    end
    dut_valid = 1'b0; dut_finish = 1'b0;
    chk("done_seen", 64'(done), 1);
    chk("done_at", 64'(j - 1), 64'(end_ev));
    chk("err_code", 64'(err_code), 64'(code));
    if (code == 1 || code == 2) chk("err_idx", 64'(err_idx), 64'(idx));
    chk("pat_cycles", 64'(pat_cycles), 64'(cyc));
    chk("pass_done", 64'(chk_pass), 64'(code == 0));
    chk("busy_done", 64'(chk_busy), 1);
    chk("total", 64'(total_cycles), 64'(tb_cyc - first_cyc));
    tick();
    chk("done_one", 64'(chk_done), 0);
    chk("busy_idle", 64'(chk_busy), 0);
    chk("pass_hold", 64'(chk_pass), 64'(code == 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {56'(0), dut_srst, dut_start, chk_busy, chk_done, chk_pass, err_code, 1'b0}, 0);
    chk({tag, "_idx"}, 64'(err_idx), 0);
    chk({tag, "_pcyc"}, 64'(pat_cycles), 0);
    chk({tag, "_tcyc"}, 64'(total_cycles), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p, t, n;
    repeat (3) tick();
    chk_all_zero("reset");
    srst = 1'b0;
    tick();
    chk_all_zero("idle");

    for (int i = 0; i < NUM_PAT; i++) if (i != 3) load_rand(i);
    load_str(3, "HELLO");
    load_str(5, "");

    build(3, 5, -1, 8'h00, 0, 0);   run_check(3, 0);
    build(3, 5, 2, "X", 0, 0);      run_check(3, 0);
    build(3, 4, -1, 8'h00, 0, 0);   run_check(3, 0);
    build(3, 6, -1, 8'h00, 0, 0);   run_check(3, 0);
    build(3, 5, -1, 8'h00, 0, 1);   run_check(3, 0);
    build(3, 5, -1, 8'h00, 1, 0);   run_check(3, 1);
    build(5, 0, -1, 8'h00, 0, 0);   run_check(5, 0);
    build(5, 1, -1, 8'h00, 0, 0);   run_check(5, 0);

    for (int k = 0; k < 30; k++) begin
      p = $urandom_range(0, NUM_PAT - 1);
      t = $urandom_range(0, 4);
      case (t)
        0: build(p, gl[p], -1, 8'h00, 0, 0);
        1: build(p, gl[p], -1, 8'h00, 1, 0);
        2: begin
          n = (gl[p] > 0) ? $urandom_range(0, gl[p] - 1) : -1;
          build(p, gl[p], n, (n >= 0) ? gm[p][n] ^ 8'($urandom_range(1, 255)) : 8'h00, $urandom_range(0, 1), 0);
        end
        3: build(p, (gl[p] > 0) ? $urandom_range(0, gl[p] - 1) : 0, -1, 8'h00, $urandom_range(0, 1), 0);
        default: build(p, gl[p] + $urandom_range(1, 3), -1, 8'h00, $urandom_range(0, 1), 0);
      endcase
      run_check(p, t == 0);
    end

    // Abort mid-run, then re-check without reloading.
    build(3, 5, -1, 8'h00, 0, 0);
    start_seq(3);
    dut_valid = 1'b1; dut_data = "H";
    tick();
    dut_data = "E";
    tick();
    dut_valid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    started_m = 0;
    chk_all_zero("abort");
    tick();
    chk_all_zero("abort_idle");
    build(3, 5, -1, 8'h00, 0, 0);
    run_check(3, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
